core_ctrl_fsm: RTL and testbench

- Multi-cycle sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB, and generates the strobes and selects for the instruction register, the clocked decoder, the register file, the PC and the memory ports.
- It handles the imem/dmem req/ready handshakes, times out stalled memory, traps illegal opcodes, halts on SYSTEM, and counts retired instructions.

---
 rtl/core_ctrl_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle sequencer for the RV32I core: steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB and drives the datapath strobes and selects.
module core_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dec_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [2:0]       dmem_size,
    output logic             alu_src_imm,
    output logic             alu_src_pc,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state,
    output logic [1:0]       trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
        C_LOAD, C_STORE, C_OPIMM, C_OP, C_FENCE, C_SYSTEM
    } class_t;

    // Wait-counter value on the last permitted waiting cycle.
    localparam logic [7:0] TLIM = 8'(MEM_TIMEOUT - 1);

    state_t     st;
    class_t     cls;
    class_t     dec_cls;
    logic       taken;
    logic [7:0] tcnt;

    assign state = st;

    always_comb begin
        dec_cls = C_ILLEGAL;
        case (opcode)
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b1100011: dec_cls = C_BRANCH;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b0010011: dec_cls = C_OPIMM;
            7'b0110011: dec_cls = C_OP;
            7'b0001111: dec_cls = C_FENCE;
            7'b1110011: dec_cls = C_SYSTEM;
            default:    dec_cls = C_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= S_FETCH;
            cls         <= C_ILLEGAL;
            taken       <= 1'b0;
            tcnt        <= 8'd0;
            instr_count <= '0;
            trap_cause  <= 2'b00;
        end else begin
            if (retire) instr_count <= instr_count + CNT_W'(1);
            case (st)
                S_FETCH: begin
                    if (imem_ready) begin
                        st <= S_DECODE;
                    end else if (tcnt == TLIM) begin
                        st         <= S_TRAP;
                        trap_cause <= 2'b10;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    cls <= dec_cls;
                    if (dec_cls == C_SYSTEM) begin
                        st <= S_HALT;
                    end else if (dec_cls == C_ILLEGAL) begin
                        st         <= S_TRAP;
                        trap_cause <= 2'b01;
                    end else begin
                        st <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    taken <= branch_taken;
                    if (cls == C_LOAD || cls == C_STORE) begin
                        st   <= S_MEM;
                        tcnt <= 8'd0;
                    end else begin
                        st <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (cls == C_LOAD) begin
                            st <= S_WB;
                        end else begin
                            st   <= S_FETCH;
                            tcnt <= 8'd0;
                        end
                    end else if (tcnt == TLIM) begin
                        st         <= S_TRAP;
                        trap_cause <= 2'b11;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_WB: begin
                    st   <= S_FETCH;
                    tcnt <= 8'd0;
                end
                default: st <= st;
            endcase
        end
    end

    // Strobes are combinational so ready-qualified pulses land in the same cycle;
    // everything is forced low while rst is held so an aborted instruction never commits.
    always_comb begin
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        dec_en      = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_size   = 3'b000;
        alu_src_imm = 1'b0;
        alu_src_pc  = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = 2'b00;
        pc_we       = 1'b0;
        pc_sel      = 2'b00;
        retire      = 1'b0;
        if (!rst) begin
            case (st)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ready;
                end
                S_DECODE: dec_en = 1'b1;
                S_EXECUTE: begin
                    alu_src_imm = (cls != C_OP) && (cls != C_LUI) && (cls != C_FENCE);
                    alu_src_pc  = (cls == C_AUIPC) || (cls == C_JAL) || (cls == C_BRANCH);
                end
                S_MEM: begin
                    dmem_req  = 1'b1;
                    dmem_we   = (cls == C_STORE);
                    dmem_size = func3;
                    if (dmem_ready && cls == C_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_WB: begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    case (cls)
                        C_OP, C_OPIMM, C_AUIPC: rf_we = 1'b1;
                        C_LOAD: begin
                            rf_we  = 1'b1;
                            wb_sel = 2'b01;
                        end
                        C_LUI: begin
                            rf_we  = 1'b1;
                            wb_sel = 2'b11;
                        end
                        C_JAL: begin
                            rf_we  = 1'b1;
                            wb_sel = 2'b10;
                            pc_sel = 2'b01;
                        end
                        C_JALR: begin
                            rf_we  = 1'b1;
                            wb_sel = 2'b10;
                            pc_sel = 2'b10;
                        end
                        C_BRANCH: pc_sel = taken ? 2'b01 : 2'b00;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm: per-cycle expected output snapshots are
// queued by the driver and compared by an independent negedge monitor.
module tb_core_ctrl_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] cause;
    logic       imem_req;
    logic       ir_load;
    logic       dec_en;
    logic       dmem_req;
    logic       dmem_we;
    logic [2:0] dsize;
    logic       asi;
    logic       asp;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       retire;
    logic [7:0] cnt;
  } snap_t;

  localparam int W = $bits(snap_t);

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        branch_taken;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req, ir_load, dec_en, dmem_req, dmem_we;
  logic [2:0]  dmem_size;
  logic        alu_src_imm, alu_src_pc, rf_we, pc_we, retire;
  logic [1:0]  wb_sel, pc_sel, trap_cause;
  logic [31:0] instr_count;
  logic [2:0]  state;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           exp_cnt = 0;
  logic [1:0]   exp_cause = 2'b00;
  string        tname = "init";
  snap_t        act;

  core_ctrl_fsm #(.MEM_TIMEOUT(255), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_load(ir_load), .dec_en(dec_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size),
    .alu_src_imm(alu_src_imm), .alu_src_pc(alu_src_pc), .rf_we(rf_we),
    .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire),
    .instr_count(instr_count), .state(state), .trap_cause(trap_cause)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  always_comb begin
    act.st       = state;
    act.cause    = trap_cause;
    act.imem_req = imem_req;
    act.ir_load  = ir_load;
    act.dec_en   = dec_en;
    act.dmem_req = dmem_req;
    act.dmem_we  = dmem_we;
    act.dsize    = dmem_size;
    act.asi      = alu_src_imm;
    act.asp      = alu_src_pc;
    act.rf_we    = rf_we;
    act.wb_sel   = wb_sel;
    act.pc_we    = pc_we;
    act.pc_sel   = pc_sel;
    act.retire   = retire;
    act.cnt      = instr_count[7:0];
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h (state %0d/%0d cnt %0d/%0d)",
                 tname, act, e, act.st, e.st, act.cnt, e.cnt);
      end
    end
  end

  // driver tasks
  function automatic snap_t base(input logic [2:0] s);
    snap_t e;
    e       = '0;
    e.st    = s;
    e.cause = exp_cause;
    e.cnt   = exp_cnt[7:0];
    return e;
  endfunction

  task automatic push_step(input snap_t e);
    exp_q.push_back(W'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_c(input logic rdy, input logic [31:0] instr);
    snap_t e;
    imem_ready = rdy;
    opcode     = instr[6:0];
    func3      = instr[14:12];
    e          = base(3'd0);
    e.imem_req = 1'b1;
    e.ir_load  = rdy;
    push_step(e);
    imem_ready = 1'b0;
  endtask

  task automatic decode_c();
    snap_t e;
    e        = base(3'd1);
    e.dec_en = 1'b1;
    push_step(e);
  endtask

  task automatic exec_c(input logic asi, input logic asp, input logic bt);
    snap_t e;
    branch_taken = bt;
    e     = base(3'd2);
    e.asi = asi;
    e.asp = asp;
    push_step(e);
    branch_taken = ~bt;
  endtask

  task automatic mem_c(input logic rdy, input logic store, input logic [2:0] size);
    snap_t e;
    dmem_ready = rdy;
    e          = base(3'd3);
    e.dmem_req = 1'b1;
    e.dmem_we  = store;
    e.dsize    = size;
    if (rdy && store) begin
      e.pc_we  = 1'b1;
      e.retire = 1'b1;
    end
    push_step(e);
    dmem_ready = 1'b0;
    if (rdy && store) exp_cnt++;
  endtask

  task automatic wb_c(input logic rf, input logic [1:0] wbs, input logic [1:0] pcs);
    snap_t e;
    e        = base(3'd4);
    e.rf_we  = rf;
    e.wb_sel = wbs;
    e.pc_we  = 1'b1;
    e.pc_sel = pcs;
    e.retire = 1'b1;
    push_step(e);
    exp_cnt++;
  endtask

  task automatic idle_c(input logic [2:0] s);
    push_step(base(s));
  endtask

  task automatic run_simple(input logic [31:0] instr, input logic asi, input logic asp,
                            input logic bt, input logic rf, input logic [1:0] wbs,
                            input logic [1:0] pcs);
    fetch_c(1'b1, instr);
    decode_c();
    exec_c(asi, asp, bt);
    wb_c(rf, wbs, pcs);
  endtask

  // Two reset cycles: the first still shows the old state with all strobes low.
  task automatic do_reset(input logic [2:0] cur);
    rst        = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    idle_c(cur);
    exp_cnt    = 0;
    exp_cause  = 2'b00;
    idle_c(3'd0);
    rst        = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; func3 = 3'd0; branch_taken = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    tname = "add";     run_simple(32'h002080b3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    checks++;
    if (instr_count !== 32'd1) begin
      errors++;
      $display("FAIL add_count: got %0d required 1", instr_count);
    end

    tname = "addi_wait";
    repeat (3) fetch_c(1'b0, 32'hfff38293);
    fetch_c(1'b1, 32'hfff38293);
    decode_c();
    exec_c(1'b1, 1'b0, 1'b0);
    wb_c(1'b1, 2'b00, 2'b00);
    tname = "jal";     run_simple(32'hffdff1ef, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b01);
    tname = "beq_nt";  run_simple(32'h00208463, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    tname = "beq_t";   run_simple(32'h00208463, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01);
    tname = "jalr";    run_simple(32'h000080e7, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10);
    tname = "lui";     run_simple(32'h123450b7, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00);
    tname = "auipc";   run_simple(32'h00001097, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    tname = "fence";   run_simple(32'h0000000f, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

    tname = "lw_wait";
    fetch_c(1'b1, 32'h0000a083);
    decode_c();
    exec_c(1'b1, 1'b0, 1'b0);
    mem_c(1'b0, 1'b0, 3'b010);
    mem_c(1'b0, 1'b0, 3'b010);
    mem_c(1'b1, 1'b0, 3'b010);
    wb_c(1'b1, 2'b01, 2'b00);

    tname = "sw";
    fetch_c(1'b1, 32'h0010a023);
    decode_c();
    exec_c(1'b1, 1'b0, 1'b0);
    mem_c(1'b1, 1'b1, 3'b010);

    tname = "lb_abort";
    fetch_c(1'b1, 32'h00008083);
    decode_c();
    exec_c(1'b1, 1'b0, 1'b0);
    mem_c(1'b0, 1'b0, 3'b000);
    do_reset(3'd3);
    tname = "after_abort";
    fetch_c(1'b0, 32'h0);

    tname = "halt";
    fetch_c(1'b1, 32'h00000073);
    decode_c();
    imem_ready = 1'b1;
    repeat (3) idle_c(3'd5);
    imem_ready = 1'b0;
    do_reset(3'd5);

    tname = "illegal";
    fetch_c(1'b1, 32'h00000000);
    decode_c();
    exp_cause  = 2'b01;
    imem_ready = 1'b1;
    repeat (3) idle_c(3'd6);
    imem_ready = 1'b0;
    do_reset(3'd6);

    tname = "imem_limit_ready";
    repeat (254) fetch_c(1'b0, 32'h002080b3);
    run_simple(32'h002080b3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);

    tname = "imem_timeout";
    repeat (255) fetch_c(1'b0, 32'h002080b3);
    exp_cause = 2'b10;
    repeat (2) idle_c(3'd6);
    do_reset(3'd6);

    tname = "dmem_timeout";
    fetch_c(1'b1, 32'h0000a083);
    decode_c();
    exec_c(1'b1, 1'b0, 1'b0);
    repeat (255) mem_c(1'b0, 1'b0, 3'b010);
    exp_cause = 2'b11;
    repeat (2) idle_c(3'd6);
    do_reset(3'd6);

    tname = "final_reset";
    fetch_c(1'b0, 32'h0);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL final_state: got %0d required 0", state);
    end
    checks++;
    if (trap_cause !== 2'b00) begin
      errors++;
      $display("FAIL final_cause: got %0d required 0", trap_cause);
    end
    checks++;
    if (instr_count !== 32'd0) begin
      errors++;
      $display("FAIL final_count: got %0d required 0", instr_count);
    end

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
